// File: rtl/mux_rr_feeder.sv
// Two-channel round-robin feeder for a 2:1 mux stage.
// Drives the mux select and registers the muxed beat with its source tag.
module mux_rr_feeder #(
    parameter int DATA_W    = 2,
    parameter int BURST_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              select,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] OWN_A = 1'b0;
    localparam logic [0:0] OWN_B = 1'b1;

    logic [0:0]       owner;
    logic [CNT_W-1:0] burst_cnt;

    logic load_en;
    logic gnt_any;
    logic gnt_b;
    logic keep_owner;
    logic xfer_a;
    logic xfer_b;

    // Grant decision. A zero burst count means nobody has been served
    // yet, so the non-owner (A after reset) wins the first tie.
    always_comb begin
        gnt_any    = a_valid | b_valid;
        keep_owner = (burst_cnt != '0) && (burst_cnt < CNT_MAX);
        gnt_b      = 1'b0;
        if (a_valid && b_valid) begin
            if (keep_owner)
                gnt_b = (owner == OWN_B);
            else
                gnt_b = (owner == OWN_A);
        end else begin
            gnt_b = b_valid;
        end
    end

    // Handshake and mux select; nothing is accepted while in reset.
    always_comb begin
        load_en = (!out_valid || out_ready) && !rst;
        a_ready = load_en & gnt_any & ~gnt_b;
        b_ready = load_en & gnt_any & gnt_b;
        xfer_a  = a_valid & a_ready;
        xfer_b  = b_valid & b_ready;
        if (rst)
            select = 1'b0;
        else if (gnt_any)
            select = gnt_b;
        else
            select = owner[0];
    end

    // Output register: load the granted beat, drain when idle, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (load_en) begin
            if (xfer_a) begin
                out_valid <= 1'b1;
                out_data  <= a_data;
                out_src   <= 1'b0;
            end else if (xfer_b) begin
                out_valid <= 1'b1;
                out_data  <= b_data;
                out_src   <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Owner FSM: count beats of the current owner, hand over on a switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_B;
            burst_cnt <= '0;
        end else if (xfer_a || xfer_b) begin
            if ((xfer_b ? OWN_B : OWN_A) == owner) begin
                if (burst_cnt != CNT_MAX)
                    burst_cnt <= burst_cnt + CNT_ONE;
            end else begin
                owner     <= xfer_b ? OWN_B : OWN_A;
                burst_cnt <= CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed bench for mux_rr_feeder: vector table on a BURST_LEN=1
// instance plus burst and reset sequences on a BURST_LEN=3 instance.
module tb_mux_rr_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, out_ready;
    logic [1:0] a_data, b_data;

    logic       a_ready1, b_ready1, select1, out_valid1, out_src1;
    logic [1:0] out_data1;
    logic       a_ready3, b_ready3, select3, out_valid3, out_src3;
    logic [1:0] out_data3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_rr_feeder #(.DATA_W(2), .BURST_LEN(1)) u1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .select(select1), .out_valid(out_valid1), .out_data(out_data1),
        .out_src(out_src1), .out_ready(out_ready)
    );

    mux_rr_feeder #(.DATA_W(2), .BURST_LEN(3)) u3 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready3),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready3),
        .select(select3), .out_valid(out_valid3), .out_data(out_data3),
        .out_src(out_src3), .out_ready(out_ready)
    );

    typedef struct {
        logic       av;
        logic [1:0] ad;
        logic       bv;
        logic [1:0] bd;
        logic       ordy;
        logic       e_ar;
        logic       e_br;
        logic       e_sel;
        logic       e_ov;
        logic [1:0] e_od;
        logic       e_os;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int bsrc[7];
        bsrc = '{0, 0, 0, 1, 1, 1, 0};

        // av ad bv bd ordy | ar br sel ov od os
        // alternation, BURST_LEN=1
        vecs[0]  = '{1, 2'b01, 1, 2'b10, 1, 1, 0, 0, 0, 2'b00, 0};
        vecs[1]  = '{1, 2'b01, 1, 2'b10, 1, 0, 1, 1, 1, 2'b01, 0};
        vecs[2]  = '{1, 2'b01, 1, 2'b10, 1, 1, 0, 0, 1, 2'b10, 1};
        vecs[3]  = '{1, 2'b01, 1, 2'b10, 1, 0, 1, 1, 1, 2'b01, 0};
        // single source B, five beats of 11
        vecs[4]  = '{0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 1, 2'b10, 1};
        vecs[5]  = '{0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 1, 2'b11, 1};
        vecs[6]  = '{0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 1, 2'b11, 1};
        vecs[7]  = '{0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 1, 2'b11, 1};
        vecs[8]  = '{0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 1, 2'b11, 1};
        // A beat 01 loads, then 4 cycles of backpressure
        vecs[9]  = '{1, 2'b01, 0, 2'b00, 1, 1, 0, 0, 1, 2'b11, 1};
        vecs[10] = '{1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0};
        vecs[11] = '{1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0};
        vecs[12] = '{1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0};
        vecs[13] = '{1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0};
        // release: old beat leaves, new beat loads on the same edge
        vecs[14] = '{1, 2'b10, 0, 2'b00, 1, 1, 0, 0, 1, 2'b01, 0};
        // idle: select holds owner, output drains
        vecs[15] = '{0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 1, 2'b10, 0};
        vecs[16] = '{0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0};
        vecs[17] = '{0, 2'b00, 1, 2'b01, 1, 0, 1, 1, 0, 2'b00, 0};
        vecs[18] = '{0, 2'b00, 0, 2'b00, 1, 0, 0, 1, 1, 2'b01, 1};

        // reset with both channels valid
        rst = 1'b1;
        a_valid = 1'b1; a_data = 2'b01;
        b_valid = 1'b1; b_data = 2'b10;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_a_ready", a_ready1, 0);
        chk("rst_b_ready", b_ready1, 0);
        chk("rst_select", select1, 0);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_out_data", out_data1, 0);
        chk("rst_out_src", out_src1, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            a_valid = vecs[i].av; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_data = vecs[i].bd;
            out_ready = vecs[i].ordy;
            #2;
            chk($sformatf("v%0d_a_ready", i), a_ready1, vecs[i].e_ar);
            chk($sformatf("v%0d_b_ready", i), b_ready1, vecs[i].e_br);
            chk($sformatf("v%0d_select", i), select1, vecs[i].e_sel);
            chk($sformatf("v%0d_out_valid", i), out_valid1, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), out_data1, vecs[i].e_od);
                chk($sformatf("v%0d_out_src", i), out_src1, vecs[i].e_os);
            end
            @(negedge clk);
        end

        // burst of 3 with both channels valid
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b1; a_data = 2'b01;
        b_valid = 1'b1; b_data = 2'b10;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d_valid", k), out_valid3, 1);
            chk($sformatf("burst%0d_src", k), out_src3, bsrc[k]);
            chk($sformatf("burst%0d_data", k), out_data3,
                bsrc[k] ? 2 : 1);
        end

        // asynchronous reset while a beat is pending
        @(posedge clk);
        #3;
        chk("mid_pre_valid", out_valid1, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid1", out_valid1, 0);
        chk("mid_rst_valid3", out_valid3, 0);
        chk("mid_rst_a_ready", a_ready1, 0);
        chk("mid_rst_b_ready", b_ready1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post_rst_a_ready", a_ready1, 1);
        chk("post_rst_select", select1, 0);
        chk("post_rst_a_ready3", a_ready3, 1);
        @(posedge clk);
        #1;
        chk("post_rst_src", out_src1, 0);
        chk("post_rst_data", out_data1, 1);
        chk("post_rst_src3", out_src3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
